exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  EXE stage directly downstream of the ID/EXE pipeline register. It applies operand
//  forwarding, builds Val2 with the ARM shifter, runs the ALU and computes the branch target.
//  It owns the CPSR status register (NZCV) and the EXE/MEM pipeline register feeding MEM.
//  Sequential state: status register plus the EXE/MEM register, with freeze (hold) support.
// PARAMETERS
//  DW      32  datapath width (ALU, PC, operands)
//  RW       4  register-index width
// PORTS
//  clk              in   1   rising-edge clock
//  rst              in   1   asynchronous reset, active-low (0 = reset)
//  freeze           in   1   1 = hold the EXE/MEM register and status register (MEM stall)
//  WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE  in  1 each  controls from ID/EXE
//  exe_cmd_EXE      in   4   ALU command
//  pc_EXE           in   DW  PC carried with the instruction
//  rn_val_EXE, rm_val_EXE  in  DW  register-file operands
//  imm_EXE          in   1   1 = immediate operand2
//  shifter_operand_EXE in 12 operand2 field
//  signed_imm_24_EXE in  24  branch offset, in words
//  dest_EXE         in   RW  destination register
//  sel_src1, sel_src2 in 2   forwarding select: 00 reg, 01 alu_res_MEM, 10 wb_val_WB, 11 = 00
//  wb_val_WB        in   DW  write-back value for forwarding
//  branch_taken     out  1   combinational, = B_EXE; upstream uses it to flush IF/ID and ID/EXE
//  branch_addr      out  DW  combinational, pc_EXE + (sext(signed_imm_24_EXE) << 2)
//  status           out  4   registered NZCV {N,Z,C,V}; fed to ID condition check
//  WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  out  1 each  registered controls
//  alu_res_MEM      out  DW  registered ALU result; also the forwarding source
//  st_val_MEM       out  DW  registered forwarded Rm (store data)
//  dest_MEM         out  RW  registered destination register
// BEHAVIOUR
//  Reset (rst=0, async): every registered output = 0, including status = 4'b0000.
//  Operand mux: op1 = sel_src1-selected Rn; fwdRm = sel_src2-selected Rm.
//  Val2, in priority order:
//  - MEM_R_EN_EXE | MEM_W_EN_EXE: zext(shifter_operand[11:0]).
//  - imm_EXE: ROR(zext(so[7:0]), 2*so[11:8]).
//  - otherwise: fwdRm shifted by so[11:7] with type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
//  - Shift amount 0 passes fwdRm unchanged. No RRX.
//  ALU by exe_cmd, C = status.C:
//  - 0001 MOV: Val2.   1001 MVN: ~Val2.
//  - 0010 ADD/LDR/STR: op1+Val2.   0011 ADC: op1+Val2+C.
//  - 0100 SUB/CMP: op1-Val2.   0101 SBC: op1-Val2-!C.
//  - 0110 AND/TST: op1&Val2.   0111 ORR.   1000 EOR.   Other codes: result 0, flags unchanged.
//  Flags: N=res[31]; Z=(res==0).
//  - Arithmetic: C = carry-out (SUB: C = no-borrow); V = signed overflow.
//  - Logic/move: C and V keep the old value.
//  Status register: loads {N,Z,C,V} on a clk edge when S_EXE=1 and freeze=0; otherwise holds.
//  EXE/MEM register: loads on every clk edge when freeze=0; freeze=1 holds all fields.
//  - A bubble (all controls 0) propagates as WB_EN_MEM = MEM_R_EN_MEM = MEM_W_EN_MEM = 0.
//  Latency: 1 cycle from EXE inputs to *_MEM and to status.
//  Same-cycle S_EXE with freeze=1: no flag update. The held instruction re-presents and updates once.
//  Reset asserted mid-operation clears everything immediately; no pending update survives.
//  All arithmetic is mod 2^DW.
// TESTING
//  1. ADD, S=1, rn=0x7FFFFFFF, imm Val2=1 -> alu_res_MEM=0x80000000, status=1001 (N,V).
//  2. SUB/CMP, S=1, rn=5, rm=5 (LSL 0) -> alu_res=0, status=0110 (Z,C);
//     repeat with S=0 -> status unchanged.
//  3. Forwarding: sel_src1=01, prior alu_res_MEM=0x10; sel_src2=10, wb_val_WB=3; ADD reg
//     -> alu_res=0x13.
//  4. Shifter: rm=0x80000000, ASR #4 -> MOV gives 0xF8000000;
//     imm so=0x4FF -> Val2 = 0xFF000000.
//  5. freeze=1 for 3 cycles during an ADC with S=1 -> *_MEM and status held; single update
//     after release.
//  6. B_EXE=1, pc=0x100, imm24=0xFFFFFE -> branch_taken=1, branch_addr=0xF8.
//     rst=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - EXE stage: forwarding, ARM shifter, ALU, branch target, NZCV and EXE/MEM register
module exe_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          WB_EN_EXE,
    input  logic          MEM_R_EN_EXE,
    input  logic          MEM_W_EN_EXE,
    input  logic          S_EXE,
    input  logic          B_EXE,
    input  logic [3:0]    exe_cmd_EXE,
    input  logic [DW-1:0] pc_EXE,
    input  logic [DW-1:0] rn_val_EXE,
    input  logic [DW-1:0] rm_val_EXE,
    input  logic          imm_EXE,
    input  logic [11:0]   shifter_operand_EXE,
    input  logic [23:0]   signed_imm_24_EXE,
    input  logic [RW-1:0] dest_EXE,
    input  logic [1:0]    sel_src1,
    input  logic [1:0]    sel_src2,
    input  logic [DW-1:0] wb_val_WB,
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr,
    output logic [3:0]    status,
    output logic          WB_EN_MEM,
    output logic          MEM_R_EN_MEM,
    output logic          MEM_W_EN_MEM,
    output logic [DW-1:0] alu_res_MEM,
    output logic [DW-1:0] st_val_MEM,
    output logic [RW-1:0] dest_MEM
);

    logic [DW-1:0]   op1;
    logic [DW-1:0]   fwd_rm;
    logic [DW-1:0]   val2;
    logic [DW-1:0]   imm_ext;
    logic [2*DW-1:0] rot_dbl;
    logic [4:0]      sh_amt;
    logic [DW-1:0]   alu_res;
    logic [DW:0]     sum;
    logic            c_in;
    logic            flag_c;
    logic            flag_v;
    logic            flag_upd;
    logic [3:0]      next_status;

    assign branch_taken = B_EXE;
    assign branch_addr  = pc_EXE + ({{(DW-24){signed_imm_24_EXE[23]}}, signed_imm_24_EXE} << 2);

    always_comb begin
        case (sel_src1)
            2'b01:   op1 = alu_res_MEM;
            2'b10:   op1 = wb_val_WB;
            default: op1 = rn_val_EXE;
        endcase
        case (sel_src2)
            2'b01:   fwd_rm = alu_res_MEM;
            2'b10:   fwd_rm = wb_val_WB;
            default: fwd_rm = rm_val_EXE;
        endcase
    end

    // Rotations use a doubled word so a zero amount falls out naturally.
    always_comb begin
        imm_ext = {{(DW-8){1'b0}}, shifter_operand_EXE[7:0]};
        sh_amt  = shifter_operand_EXE[11:7];
        rot_dbl = '0;
        val2    = fwd_rm;
        if (MEM_R_EN_EXE || MEM_W_EN_EXE) begin
            val2 = {{(DW-12){1'b0}}, shifter_operand_EXE};
        end else if (imm_EXE) begin
            rot_dbl = {imm_ext, imm_ext} >> {shifter_operand_EXE[11:8], 1'b0};
            val2    = rot_dbl[DW-1:0];
        end else begin
            case (shifter_operand_EXE[6:5])
                2'b00: val2 = fwd_rm << sh_amt;
                2'b01: val2 = fwd_rm >> sh_amt;
                2'b10: val2 = $signed(fwd_rm) >>> sh_amt;
                default: begin
                    rot_dbl = {fwd_rm, fwd_rm} >> sh_amt;
                    val2    = rot_dbl[DW-1:0];
                end
            endcase
        end
    end

    always_comb begin
        c_in     = status[1];
        sum      = '0;
        alu_res  = '0;
        flag_c   = status[1];
        flag_v   = status[0];
        flag_upd = 1'b1;
        case (exe_cmd_EXE)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                sum     = {1'b0, op1} + {1'b0, val2}
                        + {{DW{1'b0}}, (exe_cmd_EXE[0] & c_in)};
                alu_res = sum[DW-1:0];
                flag_c  = sum[DW];
                flag_v  = (op1[DW-1] == val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
            end
            4'b0100, 4'b0101: begin
                // SBC borrows one extra when C is clear; carry out is "no borrow".
                sum     = {1'b0, op1} - {1'b0, val2}
                        - {{DW{1'b0}}, (exe_cmd_EXE[0] & ~c_in)};
                alu_res = sum[DW-1:0];
                flag_c  = ~sum[DW];
                flag_v  = (op1[DW-1] != val2[DW-1]) && (alu_res[DW-1] != op1[DW-1]);
            end
            4'b0110: alu_res = op1 & val2;
            4'b0111: alu_res = op1 | val2;
            4'b1000: alu_res = op1 ^ val2;
            default: begin
                alu_res  = '0;
                flag_upd = 1'b0;
            end
        endcase
        next_status = {alu_res[DW-1], (alu_res == '0), flag_c, flag_v};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status       <= 4'b0000;
            WB_EN_MEM    <= 1'b0;
            MEM_R_EN_MEM <= 1'b0;
            MEM_W_EN_MEM <= 1'b0;
            alu_res_MEM  <= '0;
            st_val_MEM   <= '0;
            dest_MEM     <= '0;
        end else if (!freeze) begin
            if (S_EXE && flag_upd) begin
                status <= next_status;
            end
            WB_EN_MEM    <= WB_EN_EXE;
            MEM_R_EN_MEM <= MEM_R_EN_EXE;
            MEM_W_EN_MEM <= MEM_W_EN_EXE;
            alu_res_MEM  <= alu_res;
            st_val_MEM   <= fwd_rm;
            dest_MEM     <= dest_EXE;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - randomized and directed checks of exe_stage against a behavioural model
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze;
    logic        WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE;
    logic [3:0]  exe_cmd_EXE;
    logic [31:0] pc_EXE, rn_val_EXE, rm_val_EXE;
    logic        imm_EXE;
    logic [11:0] shifter_operand_EXE;
    logic [23:0] signed_imm_24_EXE;
    logic [3:0]  dest_EXE;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] wb_val_WB;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
    logic [31:0] alu_res_MEM, st_val_MEM;
    logic [3:0]  dest_MEM;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_alu, m_st;
    logic [3:0]  m_status, m_dest;
    logic        m_wb, m_mr, m_mw;

    exe_stage #(.DW(32), .RW(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
        .S_EXE(S_EXE), .B_EXE(B_EXE), .exe_cmd_EXE(exe_cmd_EXE), .pc_EXE(pc_EXE),
        .rn_val_EXE(rn_val_EXE), .rm_val_EXE(rm_val_EXE), .imm_EXE(imm_EXE),
        .shifter_operand_EXE(shifter_operand_EXE), .signed_imm_24_EXE(signed_imm_24_EXE),
        .dest_EXE(dest_EXE), .sel_src1(sel_src1), .sel_src2(sel_src2), .wb_val_WB(wb_val_WB),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
        .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
        .alu_res_MEM(alu_res_MEM), .st_val_MEM(st_val_MEM), .dest_MEM(dest_MEM)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror1_n(input logic [31:0] x, input int n);
        logic [31:0] r = x;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] asr_n(input logic [31:0] x, input int n);
        logic [31:0] r = x;
        for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                         input logic [31:0] mem_v, input logic [31:0] wb_v);
        if (sel == 2'b01) return mem_v;
        if (sel == 2'b10) return wb_v;
        return reg_v;
    endfunction

    function automatic logic [31:0] model_val2(input logic mem, input logic imm,
                                               input logic [11:0] so, input logic [31:0] x);
        int amt = int'(so[11:7]);
        if (mem) return {20'b0, so};
        if (imm) return ror1_n({24'b0, so[7:0]}, 2 * int'(so[11:8]));
        case (so[6:5])
            2'b00:   return x << amt;
            2'b01:   return x >> amt;
            2'b10:   return asr_n(x, amt);
            default: return ror1_n(x, amt);
        endcase
    endfunction

    function automatic void model_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] st, output logic [31:0] res,
                                      output logic [3:0] nst, output bit upd);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint cin = st[1] ? 64'sd1 : 64'sd0;
        longint u = 0, s = 0;
        bit arith = 1, sub = 0;
        upd = 1;
        res = '0;
        case (cmd)
            4'd1: begin res = b;      arith = 0; end
            4'd9: begin res = ~b;     arith = 0; end
            4'd6: begin res = a & b;  arith = 0; end
            4'd7: begin res = a | b;  arith = 0; end
            4'd8: begin res = a ^ b;  arith = 0; end
            4'd2: begin u = ua + ub;       s = sa + sb; end
            4'd3: begin u = ua + ub + cin; s = sa + sb + cin; end
            4'd4: begin u = ua - ub;       s = sa - sb;             sub = 1; end
            4'd5: begin u = ua - ub - (1 - cin); s = sa - sb - (1 - cin); sub = 1; end
            default: begin upd = 0; arith = 0; end
        endcase
        if (arith) res = u[31:0];
        nst = {res[31], (res == 32'd0), st[1], st[0]};
        if (arith) begin
            nst[1] = sub ? (u >= 0) : (u >= 64'sd4294967296);
            nst[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        if (!upd) nst = st;
    endfunction

    task automatic check_regs(input string tag);
        check_eq({tag, ".status"}, 32'(status), 32'(m_status));
        check_eq({tag, ".alu"}, alu_res_MEM, m_alu);
        check_eq({tag, ".st"}, st_val_MEM, m_st);
        check_eq({tag, ".dest"}, 32'(dest_MEM), 32'(m_dest));
        check_eq({tag, ".wb"}, 32'(WB_EN_MEM), 32'(m_wb));
        check_eq({tag, ".mr"}, 32'(MEM_R_EN_MEM), 32'(m_mr));
        check_eq({tag, ".mw"}, 32'(MEM_W_EN_MEM), 32'(m_mw));
    endtask

    task automatic model_reset();
        m_alu = '0; m_st = '0; m_status = '0; m_dest = '0;
        m_wb = 0; m_mr = 0; m_mw = 0;
    endtask

    // Call with inputs set at posedge+1; returns at the next posedge+1 after checking.
    task automatic cycle(input string tag);
        logic [31:0] a, rmv, v2, res;
        logic [3:0]  nst;
        bit          upd;
        longint      off;
        #1;
        off = (signed_imm_24_EXE >= 24'h800000) ? longint'(signed_imm_24_EXE) - 64'sd16777216
                                                : longint'(signed_imm_24_EXE);
        check_eq({tag, ".btaken"}, 32'(branch_taken), 32'(B_EXE));
        check_eq({tag, ".baddr"}, branch_addr, 32'(longint'(pc_EXE) + off * 4));
        a   = pick(sel_src1, rn_val_EXE, m_alu, wb_val_WB);
        rmv = pick(sel_src2, rm_val_EXE, m_alu, wb_val_WB);
        v2  = model_val2(MEM_R_EN_EXE | MEM_W_EN_EXE, imm_EXE, shifter_operand_EXE, rmv);
        model_alu(exe_cmd_EXE, a, v2, m_status, res, nst, upd);
        @(posedge clk);
        #1;
        if (!freeze) begin
            m_alu = res; m_st = rmv; m_dest = dest_EXE;
            m_wb = WB_EN_EXE; m_mr = MEM_R_EN_EXE; m_mw = MEM_W_EN_EXE;
            if (S_EXE && upd) m_status = nst;
        end
        check_regs(tag);
    endtask

    task automatic clear_inputs();
        freeze = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0; MEM_W_EN_EXE = 0; S_EXE = 0; B_EXE = 0;
        exe_cmd_EXE = 0; pc_EXE = 0; rn_val_EXE = 0; rm_val_EXE = 0; imm_EXE = 0;
        shifter_operand_EXE = 0; signed_imm_24_EXE = 0; dest_EXE = 0;
        sel_src1 = 0; sel_src2 = 0; wb_val_WB = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rn_val_EXE = 32'hDEADBEEF;
        exe_cmd_EXE = 4'd2; S_EXE = 1; WB_EN_EXE = 1;
        #12;
        check_regs("reset");
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;

        // ADD overflow into sign bit
        exe_cmd_EXE = 4'd2; S_EXE = 1; WB_EN_EXE = 1; imm_EXE = 1;
        rn_val_EXE = 32'h7FFFFFFF; shifter_operand_EXE = 12'h001; dest_EXE = 4'd3;
        cycle("add_ovf");
        check_eq("add_ovf.res", alu_res_MEM, 32'h80000000);
        check_eq("add_ovf.nzcv", 32'(status), 32'h9);

        // CMP equal, then non-S SUB must leave flags alone
        clear_inputs();
        exe_cmd_EXE = 4'd4; S_EXE = 1; rn_val_EXE = 5; rm_val_EXE = 5;
        cycle("cmp_eq");
        check_eq("cmp_eq.res", alu_res_MEM, 32'h0);
        check_eq("cmp_eq.nzcv", 32'(status), 32'h6);
        S_EXE = 0; rn_val_EXE = 7;
        cycle("sub_nos");
        check_eq("sub_nos.nzcv", 32'(status), 32'h6);

        // Forwarding from MEM and WB
        clear_inputs();
        exe_cmd_EXE = 4'd1; imm_EXE = 1; shifter_operand_EXE = 12'h010;
        cycle("mov_10");
        clear_inputs();
        exe_cmd_EXE = 4'd2; sel_src1 = 2'b01; sel_src2 = 2'b10; wb_val_WB = 3;
        rn_val_EXE = 32'h1111; rm_val_EXE = 32'h2222;
        cycle("fwd_add");
        check_eq("fwd_add.res", alu_res_MEM, 32'h13);

        // Shifter: ASR #4 and rotated immediate
        clear_inputs();
        exe_cmd_EXE = 4'd1; rm_val_EXE = 32'h80000000; shifter_operand_EXE = 12'h240;
        cycle("mov_asr");
        check_eq("mov_asr.res", alu_res_MEM, 32'hF8000000);
        imm_EXE = 1; shifter_operand_EXE = 12'h4FF;
        cycle("mov_rot");
        check_eq("mov_rot.res", alu_res_MEM, 32'hFF000000);

        // ADC held by freeze for three cycles, then a single update
        clear_inputs();
        exe_cmd_EXE = 4'd3; S_EXE = 1; imm_EXE = 1; rn_val_EXE = 1;
        shifter_operand_EXE = 12'h002; WB_EN_EXE = 1; freeze = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("frz_hold");
            check_eq("frz_hold.res", alu_res_MEM, 32'hFF000000);
            check_eq("frz_hold.nzcv", 32'(status), 32'h6);
        end
        freeze = 0;
        cycle("frz_rel");
        check_eq("frz_rel.res", alu_res_MEM, 32'h4);
        check_eq("frz_rel.nzcv", 32'(status), 32'h0);
        clear_inputs();
        cycle("bubble");
        check_eq("bubble.wb", 32'(WB_EN_MEM), 32'h0);
        check_eq("bubble.nzcv", 32'(status), 32'h0);

        // Backward branch
        B_EXE = 1; pc_EXE = 32'h100; signed_imm_24_EXE = 24'hFFFFFE;
        #1;
        check_eq("branch.taken", 32'(branch_taken), 32'h1);
        check_eq("branch.addr", branch_addr, 32'hF8);
        cycle("branch");

        for (int i = 0; i < 400; i++) begin
            freeze       = ($urandom_range(0, 4) == 0);
            WB_EN_EXE    = 1'($urandom);
            MEM_R_EN_EXE = ($urandom_range(0, 5) == 0);
            MEM_W_EN_EXE = ($urandom_range(0, 5) == 0);
            S_EXE        = 1'($urandom);
            B_EXE        = 1'($urandom);
            exe_cmd_EXE  = 4'($urandom_range(0, 15));
            pc_EXE       = $urandom;
            rn_val_EXE   = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            rm_val_EXE   = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            imm_EXE      = 1'($urandom);
            shifter_operand_EXE = 12'($urandom);
            signed_imm_24_EXE   = 24'($urandom);
            dest_EXE     = 4'($urandom);
            sel_src1     = 2'($urandom);
            sel_src2     = 2'($urandom);
            wb_val_WB    = $urandom;
            cycle("rand");
        end

        // Asynchronous reset between clock edges
        clear_inputs();
        exe_cmd_EXE = 4'd9; S_EXE = 1; WB_EN_EXE = 1; dest_EXE = 4'd9;
        cycle("pre_rst");
        #3 rst = 0;
        #1;
        model_reset();
        check_regs("async_rst");
        #2 rst = 1;
        clear_inputs();
        @(posedge clk); #1;
        check_regs("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
